// File: rtl/sram_path_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sram_path_arb_pkg
// Shared types and helpers for the path-SRAM port arbiter.
//   arb_state_e : arbiter FSM states (IDLE accepts, RD waits for SRAM q)
//   DEF_*       : default widths for the 64x16 path SRAM and two requesters
//   idx_w()     : width of a requester index (at least 1 bit)
// -----------------------------------------------------------------------------
package sram_path_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RD   = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_ADDR_W  = 6;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_BE_W    = 2;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sram_path_port_arbiter_rr_priority_pick.sv
// -----------------------------------------------------------------------------
// rr_priority_pick
// Combinational round-robin picker. The search starts at the requester after
// rr_ptr and wraps modulo NUM_REQ, so the previous winner has lowest priority.
//   req     in  NUM_REQ  request vector
//   rr_ptr  in  IDX_W    index of the previous winner
//   gnt     out NUM_REQ  one-hot grant (all zero when no request)
//   gnt_idx out IDX_W    index of the granted requester
//   gnt_any out 1        some requester is granted
// -----------------------------------------------------------------------------
module rr_priority_pick
  import sram_path_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_any
);

  always_comb begin
    int cand;
    cand    = 0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (!gnt_any && req[cand]) begin
        gnt[cand] = 1'b1;
        gnt_idx   = IDX_W'(cand);
        gnt_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_path_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_path_port_arbiter
// Round-robin arbiter sharing one port of the 64x16 path SRAM between NUM_REQ
// Avalon-MM-style requesters. One access at a time: writes complete in their
// accept cycle, reads return registered data two cycles after accept.
//   clk, reset_n          clock, async active-low reset
//   req/req_write         per-requester request and direction
//   req_address/byteenable/writedata  packed per-requester fields
//   req_waitrequest       low only for the requester accepted this cycle
//   req_readdatavalid     one-cycle pulse to the owner of req_readdata
//   req_readdata          registered read data shared by all requesters
//   sram_*                SRAM port (registered address, unregistered q)
// -----------------------------------------------------------------------------
module sram_path_port_arbiter
  import sram_path_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int BE_W    = DEF_BE_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  input  logic [NUM_REQ*BE_W-1:0]   req_byteenable,
  input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
  output logic [NUM_REQ-1:0]        req_waitrequest,
  output logic [NUM_REQ-1:0]        req_readdatavalid,
  output logic [DATA_W-1:0]         req_readdata,
  output logic [ADDR_W-1:0]         sram_address,
  output logic [BE_W-1:0]           sram_byteenable,
  output logic                      sram_chipselect,
  output logic                      sram_write,
  output logic [DATA_W-1:0]         sram_writedata,
  output logic                      sram_clken,
  input  logic [DATA_W-1:0]         sram_readdata
);

  localparam int IDX_W = idx_w(NUM_REQ);

  // Reset is asserted asynchronously but released through two flops, so the
  // arbiter starts granting on a clean edge. run gates every accept.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       run;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= rst_sync_d;
  end

  assign run = rst_sync_q[1];

  arb_state_e               state_q, state_d;
  logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]       owner_oh_q, owner_oh_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [NUM_REQ-1:0]       rdv_q, rdv_d;
  logic [DATA_W-1:0]        rdata_q, rdata_d;

  logic [NUM_REQ-1:0]       gnt;
  logic [IDX_W-1:0]         gnt_idx;
  logic                     gnt_any;
  logic                     accept;

  logic                     win_write;
  logic [ADDR_W-1:0]        win_addr;
  logic [BE_W-1:0]          win_be;
  logic [DATA_W-1:0]        win_wdata;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req     (req),
    .rr_ptr  (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign accept = run && (state_q == IDLE) && gnt_any;

  // Winner field mux; gnt is one-hot so at most one branch fires.
  always_comb begin
    win_write = 1'b0;
    win_addr  = '0;
    win_be    = '0;
    win_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        win_write = req_write[i];
        win_addr  = req_address[i*ADDR_W +: ADDR_W];
        win_be    = req_byteenable[i*BE_W +: BE_W];
        win_wdata = req_writedata[i*DATA_W +: DATA_W];
      end
    end
  end

  // The address is held outside the accept cycle so the SRAM's registered
  // address keeps pointing at the read in flight during RD.
  assign req_waitrequest   = accept ? ~gnt : '1;
  assign sram_chipselect   = accept;
  assign sram_write        = accept & win_write;
  assign sram_address      = accept ? win_addr : addr_q;
  assign sram_byteenable   = accept ? win_be : '0;
  assign sram_writedata    = accept ? win_wdata : '0;
  assign sram_clken        = run;
  assign req_readdatavalid = rdv_q;
  assign req_readdata      = rdata_q;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_oh_d = owner_oh_q;
    addr_d     = addr_q;
    rdv_d      = '0;
    rdata_d    = rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rr_ptr_d = gnt_idx;
          addr_d   = win_addr;
          if (!win_write) begin
            state_d    = RD;
            owner_oh_d = gnt;
          end
        end
      end
      RD: begin
        // SRAM q reflects the address registered at the accept edge.
        rdata_d = sram_readdata;
        rdv_d   = owner_oh_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= IDX_W'(NUM_REQ - 1);
      owner_oh_q <= '0;
      addr_q     <= '0;
      rdv_q      <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_oh_q <= owner_oh_d;
      addr_q     <= addr_d;
      rdv_q      <= rdv_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_sram_path_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_path_port_arbiter
// Bench for the path-SRAM port arbiter with two requesters, a behavioural
// 64x16 SRAM with registered address, and a transaction-level reference model
// (golden memory, last-winner index, pending read) that predicts grants,
// SRAM port values and read returns every cycle.
// -----------------------------------------------------------------------------
module tb_sram_path_port_arbiter;

  localparam int N  = 2;
  localparam int AW = 6;
  localparam int DW = 16;
  localparam int BW = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N-1:0]      req;
  logic [N-1:0]      req_write;
  logic [N*AW-1:0]   req_address;
  logic [N*BW-1:0]   req_byteenable;
  logic [N*DW-1:0]   req_writedata;
  logic [N-1:0]      req_waitrequest;
  logic [N-1:0]      req_readdatavalid;
  logic [DW-1:0]     req_readdata;
  logic [AW-1:0]     sram_address;
  logic [BW-1:0]     sram_byteenable;
  logic              sram_chipselect;
  logic              sram_write;
  logic [DW-1:0]     sram_writedata;
  logic              sram_clken;
  logic [DW-1:0]     sram_readdata;

  always #5 clk = ~clk;

  sram_path_port_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .BE_W    (BW)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .req               (req),
    .req_write         (req_write),
    .req_address       (req_address),
    .req_byteenable    (req_byteenable),
    .req_writedata     (req_writedata),
    .req_waitrequest   (req_waitrequest),
    .req_readdatavalid (req_readdatavalid),
    .req_readdata      (req_readdata),
    .sram_address      (sram_address),
    .sram_byteenable   (sram_byteenable),
    .sram_chipselect   (sram_chipselect),
    .sram_write        (sram_write),
    .sram_writedata    (sram_writedata),
    .sram_clken        (sram_clken),
    .sram_readdata     (sram_readdata)
  );

  // Behavioural SRAM: write at the edge, address registered, q unregistered.
  logic [DW-1:0] sram_mem [64] = '{default: 16'h0000};
  logic [AW-1:0] sram_addr_r = '0;

  always @(posedge clk) begin
    if (sram_clken) begin
      if (sram_chipselect && sram_write)
        for (int b = 0; b < BW; b++)
          if (sram_byteenable[b]) sram_mem[sram_address][8*b +: 8] <= sram_writedata[8*b +: 8];
      sram_addr_r <= sram_address;
    end
  end

  assign sram_readdata = sram_mem[sram_addr_r];

  int errors = 0;
  int checks = 0;

  // Pending transaction per requester (held until accepted), plus presence
  // mask used to drop req temporarily.
  logic          pv   [N];
  logic          pres [N];
  logic          pw   [N];
  logic [AW-1:0] pa   [N];
  logic [BW-1:0] pb   [N];
  logic [DW-1:0] pd   [N];

  // Reference model state.
  logic [DW-1:0] ref_mem [64];
  int            m_last;
  bit            m_busy;
  int            m_owner;
  logic [AW-1:0] m_addr;
  logic [N-1:0]  exp_rdv;
  logic [DW-1:0] exp_data;

  logic [N-1:0]  obs_gnt;
  logic [N-1:0]  obs_rdv;
  logic [DW-1:0] obs_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last   = N - 1;
    m_busy   = 1'b0;
    m_owner  = 0;
    m_addr   = '0;
    exp_rdv  = '0;
    exp_data = '0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i]                      = pv[i] && pres[i];
      req_write[i]                = pw[i];
      req_address[i*AW +: AW]     = pa[i];
      req_byteenable[i*BW +: BW]  = pb[i];
      req_writedata[i*DW +: DW]   = pd[i];
    end
  endtask

  task automatic set_txn(input int i, input logic w, input logic [AW-1:0] a,
                         input logic [BW-1:0] be, input logic [DW-1:0] d);
    pv[i] = 1'b1; pres[i] = 1'b1; pw[i] = w; pa[i] = a; pb[i] = be; pd[i] = d;
  endtask

  task automatic clear_pending();
    for (int i = 0; i < N; i++) begin
      pv[i] = 1'b0; pres[i] = 1'b1;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_waitreq"}, 32'(req_waitrequest), 32'h3);
    chk({tag, "_rdv"},     32'(req_readdatavalid), 32'h0);
    chk({tag, "_cs"},      32'(sram_chipselect), 32'h0);
    chk({tag, "_wr"},      32'(sram_write), 32'h0);
    chk({tag, "_clken"},   32'(sram_clken), 32'h0);
    chk({tag, "_rdata"},   32'(req_readdata), 32'h0);
    chk({tag, "_addr"},    32'(sram_address), 32'h0);
  endtask

  // One bus cycle: drive at posedge+1, check at negedge, advance the model
  // after the next posedge.
  task automatic cycle();
    int           win;
    int           c;
    logic [N-1:0] exp_wait;
    drive();
    @(negedge clk);
    win = -1;
    if (!m_busy)
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (win < 0 && pv[c] && pres[c]) win = c;
      end
    exp_wait = '1;
    if (win >= 0) exp_wait[win] = 1'b0;
    obs_gnt   = ~req_waitrequest;
    obs_rdv   = req_readdatavalid;
    obs_rdata = req_readdata;
    chk("waitrequest", 32'(req_waitrequest), 32'(exp_wait));
    chk("chipselect",  32'(sram_chipselect), 32'(win >= 0));
    chk("clken",       32'(sram_clken), 32'h1);
    if (win >= 0) begin
      chk("sram_write",   32'(sram_write), 32'(pw[win]));
      chk("sram_address", 32'(sram_address), 32'(pa[win]));
      if (pw[win]) begin
        chk("sram_be",    32'(sram_byteenable), 32'(pb[win]));
        chk("sram_wdata", 32'(sram_writedata), 32'(pd[win]));
      end
    end
    chk("readdatavalid", 32'(req_readdatavalid), 32'(exp_rdv));
    if (exp_rdv != '0) chk("readdata", 32'(req_readdata), 32'(exp_data));
    @(posedge clk);
    #1;
    exp_rdv = '0;
    if (m_busy) begin
      exp_rdv[m_owner] = 1'b1;
      exp_data         = ref_mem[m_addr];
      m_busy           = 1'b0;
    end else if (win >= 0) begin
      m_last = win;
      if (pw[win]) begin
        for (int b = 0; b < BW; b++)
          if (pb[win][b]) ref_mem[pa[win]][8*b +: 8] = pd[win][8*b +: 8];
      end else begin
        m_busy  = 1'b1;
        m_owner = win;
        m_addr  = pa[win];
      end
      pv[win] = 1'b0;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    req = '0; req_write = '0; req_address = '0; req_byteenable = '0; req_writedata = '0;
    for (int a = 0; a < 64; a++) ref_mem[a] = '0;
    for (int i = 0; i < N; i++) begin
      pw[i] = 1'b0; pa[i] = '0; pb[i] = '0; pd[i] = '0;
    end
    clear_pending();
    model_reset();

    // Reset state, with a request pending that must not be granted.
    set_txn(0, 1'b1, 6'd1, 2'b11, 16'h1234);
    drive();
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    clear_pending();
    drive();
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("clken_after_release", 32'(sram_clken), 32'h1);

    // Both requesters hold writes continuously: 0,1,0,1,... one per cycle.
    for (int k = 0; k < 6; k++) begin
      if (!pv[0]) set_txn(0, 1'b1, AW'(10 + k), 2'b11, 16'($urandom));
      if (!pv[1]) set_txn(1, 1'b1, AW'(20 + k), 2'b11, 16'($urandom));
      cycle();
      chk("alt_order", 32'(obs_gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
    end
    clear_pending();

    // Write then read back through requester 0.
    set_txn(0, 1'b1, 6'd5, 2'b11, 16'hBEEF);
    cycle();
    set_txn(0, 1'b0, 6'd5, 2'b11, 16'h0000);
    cycle();
    chk("rd5_accept", 32'(obs_gnt), 32'h1);
    cycle();
    cycle();
    chk("rd5_rdv", 32'(obs_rdv), 32'h1);
    chk("rd5_data", 32'(obs_rdata), 32'hBEEF);

    // Simultaneous reads; req1 wrote last so req0 goes first.
    set_txn(0, 1'b1, 6'd3, 2'b11, 16'h0011);
    cycle();
    set_txn(1, 1'b1, 6'd60, 2'b11, 16'h2200);
    cycle();
    set_txn(0, 1'b0, 6'd3, 2'b11, 16'h0000);
    set_txn(1, 1'b0, 6'd60, 2'b11, 16'h0000);
    cycle();
    chk("dual_first", 32'(obs_gnt), 32'h1);
    cycle();
    cycle();
    chk("dual_rdv0", 32'(obs_rdv), 32'h1);
    chk("dual_data0", 32'(obs_rdata), 32'h0011);
    chk("dual_second", 32'(obs_gnt), 32'h2);
    cycle();
    cycle();
    chk("dual_rdv1", 32'(obs_rdv), 32'h2);
    chk("dual_data1", 32'(obs_rdata), 32'h2200);

    // Partial write of the low byte at the top address.
    set_txn(0, 1'b1, 6'd63, 2'b11, 16'hFFFF);
    cycle();
    set_txn(0, 1'b1, 6'd63, 2'b01, 16'hAA55);
    cycle();
    set_txn(0, 1'b0, 6'd63, 2'b00, 16'h0000);
    cycle();
    cycle();
    cycle();
    chk("partial_rdv", 32'(obs_rdv), 32'h1);
    chk("partial_data", 32'(obs_rdata), 32'hFF55);

    // Random traffic with dropped requests, zero byteenables and a reset
    // asserted in the middle of it.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && ($urandom % 2 == 0))
          set_txn(i, 1'($urandom), ($urandom % 4 == 0) ? AW'($urandom) : AW'($urandom_range(0, 3)),
                  BW'($urandom), 16'($urandom));
        pres[i] = ($urandom % 5) != 0;
      end
      if (n == 200) begin
        drive();
        #3;
        reset_n = 1'b0;
        #1;
        chk_reset("reset_mid");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset_hold");
        clear_pending();
        drive();
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
      end else begin
        cycle();
      end
    end
    clear_pending();
    repeat (3) cycle();

    // Reset while a read is outstanding: the read is discarded.
    set_txn(0, 1'b0, 6'd5, 2'b11, 16'h0000);
    cycle();
    chk("rdrst_accept", 32'(obs_gnt), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset("rdrst");
    model_reset();
    clear_pending();
    drive();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    repeat (3) begin
      cycle();
      chk("rdrst_no_rdv", 32'(obs_rdv), 32'h0);
    end
    set_txn(0, 1'b0, 6'd5, 2'b11, 16'h0000);
    cycle();
    chk("rdrst_new_accept", 32'(obs_gnt), 32'h1);
    cycle();
    cycle();
    chk("rdrst_new_rdv", 32'(obs_rdv), 32'h1);
    chk("rdrst_new_data", 32'(obs_rdata), 32'(ref_mem[5]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
